// File: rtl/adder_pkg.sv
// Shared types and default sizes for the pipelined adder/subtractor.
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  localparam int unsigned ADDER_DEFAULT_BIT_WIDTH = 4;
  localparam int unsigned ADDER_DEFAULT_STAGES    = 2;
  localparam int unsigned ADDER_MAX_WIDTH         = 64;

  // Sum is sized for the widest legal operand; narrower builds use the low bits only.
  typedef struct packed {
    logic [ADDER_MAX_WIDTH-1:0] sum;
    logic                       carry_out;
    logic                       overflow;
  } result_t;

endpackage

// File: rtl/pipe_adder_slot.sv
// One valid+payload register slot of the pipe_adder result pipeline.
module pipe_adder_slot
  import adder_pkg::*;
(
  input  logic    i_clk,
  input  logic    i_rst,
  input  logic    i_valid,
  input  result_t i_payload,
  input  logic    i_ready,
  output logic    o_ready,
  output logic    o_valid,
  output result_t o_payload
);

  logic    r_valid;
  result_t r_payload;

  // Load when empty or when the held beat leaves this cycle; bubbles collapse.
  assign o_ready = !r_valid || i_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid   <= 1'b0;
      r_payload <= '0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_payload <= i_payload;
      end
    end
  end

  assign o_valid   = r_valid;
  assign o_payload = r_payload;

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract with valid/ready handshake and STAGES result slots.
// Optional macro PIPE_ADDER_SAT_EN clamps signed overflow to the signed max/min.
module pipe_adder
  import adder_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = ADDER_DEFAULT_BIT_WIDTH,
  parameter int unsigned STAGES    = ADDER_DEFAULT_STAGES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  op_t                  op,
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  input  logic                 carry_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] sum,
  output logic                 carry_out,
  output logic                 overflow
);

  localparam int unsigned Msb = BIT_WIDTH - 1;

  logic [BIT_WIDTH-1:0] w_b_eff;
  logic                 w_cin;
  logic [BIT_WIDTH:0]   w_full;
  logic                 w_ovf;
  logic [BIT_WIDTH-1:0] w_sum;
  result_t              w_res;

  // SUB is a + ~b + !borrow, so one adder serves both operations.
  assign w_b_eff = (op == OP_SUB) ? ~b : b;
  assign w_cin   = (op == OP_SUB) ? ~carry_in : carry_in;
  assign w_full  = {1'b0, a} + {1'b0, w_b_eff} + {{BIT_WIDTH{1'b0}}, w_cin};
  assign w_ovf   = (a[Msb] == w_b_eff[Msb]) && (w_full[Msb] != a[Msb]);

`ifdef PIPE_ADDER_SAT_EN
  // Overflow direction follows the operand sign: positive operands clamp high.
  assign w_sum = !w_ovf  ? w_full[BIT_WIDTH-1:0] :
                 a[Msb]  ? {1'b1, {(BIT_WIDTH-1){1'b0}}} :
                           {1'b0, {(BIT_WIDTH-1){1'b1}}};
`else
  assign w_sum = w_full[BIT_WIDTH-1:0];
`endif

  always_comb begin
    w_res                     = '0;
    w_res.sum[BIT_WIDTH-1:0]  = w_sum;
    w_res.carry_out           = w_full[BIT_WIDTH];
    w_res.overflow            = w_ovf;
  end

  // Index 0 is the input side; index STAGES is the output side.
  logic [STAGES:0] w_valid;
  logic [STAGES:0] w_ready;
  result_t         w_payload [STAGES+1];

  assign w_valid[0]      = in_valid;
  assign w_payload[0]    = w_res;
  assign w_ready[STAGES] = out_ready;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_slot
    pipe_adder_slot u_slot (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_valid   (w_valid[gi]),
      .i_payload (w_payload[gi]),
      .i_ready   (w_ready[gi+1]),
      .o_ready   (w_ready[gi]),
      .o_valid   (w_valid[gi+1]),
      .o_payload (w_payload[gi+1])
    );
  end

  assign in_ready  = !rst && w_ready[0];
  assign out_valid = w_valid[STAGES];
  assign sum       = w_payload[STAGES].sum[BIT_WIDTH-1:0];
  assign carry_out = w_payload[STAGES].carry_out;
  assign overflow  = w_payload[STAGES].overflow;

  if (BIT_WIDTH < ADDER_MAX_WIDTH) begin : g_unused_hi
    logic w_unused_sum_hi;
    assign w_unused_sum_hi = ^w_payload[STAGES].sum[ADDER_MAX_WIDTH-1:BIT_WIDTH];
  end

endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder (BIT_WIDTH=4, STAGES=2); honours PIPE_ADDER_SAT_EN.
module tb_pipe_adder;
  import adder_pkg::*;

  localparam int unsigned BitWidth = 4;
  localparam int unsigned Stages   = 2;

  logic                clk;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  op_t                 op;
  logic [BitWidth-1:0] a;
  logic [BitWidth-1:0] b;
  logic                carry_in;
  logic                out_valid;
  logic                out_ready;
  logic [BitWidth-1:0] sum;
  logic                carry_out;
  logic                overflow;

  pipe_adder #(
    .BIT_WIDTH (BitWidth),
    .STAGES    (Stages)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [BitWidth-1:0] sum;
    logic                co;
    logic                ov;
    int                  cyc;
    logic                lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_out    = 0;
  int   cyc      = 0;
  logic lat_en   = 1'b0;
  exp_t mon_e;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Independent reference: signed/unsigned integer arithmetic with range checks.
  function automatic exp_t model(input op_t o, input logic [3:0] x, input logic [3:0] y,
                                 input logic ci);
    exp_t e;
    int ux, uy, sx, sy, ur, r;
    ux = int'(x);
    uy = int'(y);
    sx = (ux >= 8) ? ux - 16 : ux;
    sy = (uy >= 8) ? uy - 16 : uy;
    if (o == OP_ADD) begin
      ur   = ux + uy + int'(ci);
      r    = sx + sy + int'(ci);
      e.co = (ur >= 16);
    end else begin
      ur   = ux - uy - int'(ci);
      r    = sx - sy - int'(ci);
      e.co = (ur >= 0);
    end
    e.sum = ur[3:0];
    e.ov  = (r > 7) || (r < -8);
`ifdef PIPE_ADDER_SAT_EN
    if (r > 7) e.sum = 4'h7;
    else if (r < -8) e.sum = 4'h8;
`endif
    e.cyc = 0;
    e.lat = 1'b0;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes are sampled mid-cycle, where inputs and DUT outputs are settled.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        check_eq("sb_has_entry", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          check_eq("sum", 64'(sum), 64'(mon_e.sum));
          check_eq("carry_out", 64'(carry_out), 64'(mon_e.co));
          check_eq("overflow", 64'(overflow), 64'(mon_e.ov));
          if (mon_e.lat) check_eq("latency", 64'(cyc - mon_e.cyc), 64'(Stages));
          n_out++;
        end
      end
      if (in_valid && in_ready) begin
        mon_e     = model(op, a, b, carry_in);
        mon_e.cyc = cyc;
        mon_e.lat = lat_en;
        sb.push_back(mon_e);
      end
    end
  end

  task automatic drive_beat(input op_t o, input logic [3:0] x, input logic [3:0] y,
                            input logic ci);
    int n = 0;
    in_valid = 1'b1;
    op       = o;
    a        = x;
    b        = y;
    carry_in = ci;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check_eq("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check_eq("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n0;
    logic done;
    logic [5:0] pat;

    // Reset with a beat offered: nothing may be accepted.
    rst = 1'b1; in_valid = 1'b1; op = OP_ADD; a = 4'h3; b = 4'h3; carry_in = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    lat_en = 1'b1;
    in_valid = 1'b1; op = OP_ADD; a = 4'h7; b = 4'h1; carry_in = 1'b0;
    @(negedge clk);
    check_eq("post_rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("post_rst_sum", 64'(sum), 64'd0);
    check_eq("post_rst_carry", 64'(carry_out), 64'd0);
    check_eq("post_rst_ovf", 64'(overflow), 64'd0);
    check_eq("first_accept_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    drive_beat(OP_ADD, 4'hF, 4'h1, 1'b0);
    drive_beat(OP_SUB, 4'h3, 4'h5, 1'b0);
    drive_beat(OP_SUB, 4'h8, 4'h1, 1'b0);
    drive_beat(OP_ADD, 4'h9, 4'h9, 1'b1);
    drive_beat(OP_SUB, 4'h0, 4'h0, 1'b1);
    drain();

    // Backpressure: pipe holds two beats, outputs stay stable, order preserved.
    lat_en = 1'b0;
    out_ready = 1'b0;
    drive_beat(OP_ADD, 4'h1, 4'h0, 1'b0);
    drive_beat(OP_ADD, 4'h2, 4'h0, 1'b0);
    in_valid = 1'b1; a = 4'h3;
    repeat (3) begin
      @(negedge clk);
      check_eq("bp_in_ready_low", 64'(in_ready), 64'd0);
      check_eq("bp_out_valid", 64'(out_valid), 64'd1);
      check_eq("bp_sum_hold", 64'(sum), 64'd1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    drive_beat(OP_ADD, 4'h3, 4'h0, 1'b0);
    drive_beat(OP_ADD, 4'h4, 4'h0, 1'b0);
    drain();

    // Bubbles: latency check enforces that output gaps mirror input gaps.
    lat_en = 1'b1;
    pat = 6'b101101;
    for (int i = 5; i >= 0; i--) begin
      if (pat[i]) drive_beat(op_t'($urandom_range(0, 1)), 4'($urandom), 4'($urandom),
                             1'($urandom));
      else idle_cycles(1);
    end
    drain();

    // Full pipe, then accept and drain in the same cycle.
    lat_en = 1'b0;
    out_ready = 1'b0;
    drive_beat(OP_ADD, 4'hA, 4'h0, 1'b0);
    drive_beat(OP_ADD, 4'hB, 4'h0, 1'b0);
    out_ready = 1'b1;
    n0 = n_out;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; op = OP_SUB; a = 4'(i); b = 4'h2; carry_in = 1'b1;
      @(negedge clk);
      check_eq("full_in_ready", 64'(in_ready), 64'd1);
      check_eq("full_out_valid", 64'(out_valid), 64'd1);
      @(posedge clk);
      #1;
    end
    check_eq("full_drain_count", 64'(n_out - n0), 64'd5);
    drain();

    // Random traffic under random backpressure.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          drive_beat(op_t'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 1'($urandom));
          if ($urandom_range(0, 3) == 0) idle_cycles(1);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom);
        end
      end
    join
    drain();

    // Reset mid-flight: both held beats are discarded.
    out_ready = 1'b0;
    drive_beat(OP_ADD, 4'h5, 4'h0, 1'b0);
    drive_beat(OP_ADD, 4'h6, 4'h0, 1'b0);
    rst = 1'b1; in_valid = 1'b1; a = 4'h9;
    @(negedge clk);
    check_eq("midrst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    n0 = n_out;
    repeat (4) begin
      @(negedge clk);
      check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
    end
    check_eq("midrst_no_output", 64'(n_out - n0), 64'd0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 Parameter BIT_WIDTH, default 4: operand and sum width; legal range 2..64.
REQ-002 Parameter STAGES, default 2: pipeline register slots; legal range 1..8.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  operand beat accepted when in_valid && in_ready at a clock edge.
REQ-007 op  input  1  operation select: OP_ADD=0, OP_SUB=1.
REQ-008 a, b  input  BIT_WIDTH  operands, two's complement or unsigned.
REQ-009 carry_in  input  1  carry for ADD; borrow for SUB.
REQ-010 out_valid  output  1  result beat present.
REQ-011 out_ready  input  1  consumer takes the beat when out_valid && out_ready.
REQ-012 sum  output  BIT_WIDTH  result.
REQ-013 carry_out  output  1  unsigned carry (ADD) or not-borrow (SUB).
REQ-014 overflow  output  1  signed overflow of the result.

Function
REQ-015 ADD computes the (BIT_WIDTH+1)-bit value a + b + carry_in.
REQ-016 SUB computes the (BIT_WIDTH+1)-bit value a + ~b + !carry_in, i.e. a - b - carry_in.
REQ-017 sum is the low BIT_WIDTH bits of that value; carry_out is bit BIT_WIDTH.
REQ-018 overflow = (sign of a == sign of the effective second operand) && (sign of sum != sign of a); the effective second operand is b for ADD and ~b for SUB.
REQ-019 Arithmetic happens combinationally ahead of slot 0; slots 1..STAGES-1 only delay the result and its flags.
REQ-020 Each slot holds a valid bit plus its payload; slot STAGES-1 drives out_valid, sum, carry_out and overflow.
REQ-021 A slot loads whenever it is empty or its downstream slot is advancing; the output slot advances on out_ready. Bubbles collapse.
REQ-022 in_ready = slot 0 can load this cycle; combinational from out_ready and the slot valids; no combinational path from in_valid.
REQ-023 Latency is exactly STAGES cycles from acceptance to out_valid when out_ready is held high.
REQ-024 Throughput is one beat per cycle with no backpressure; results leave in acceptance order with none lost or duplicated.
REQ-025 With out_ready low, up to STAGES beats are held. in_ready falls only when all slots are full.
REQ-026 While out_valid && !out_ready, sum, carry_out and overflow hold stable.
REQ-027 Full pipe with accept and drain in the same cycle: the pipe advances with no loss and no bubble.

Reset
REQ-028 While rst is high, every slot valid clears at the edge and in_ready is driven 0.
REQ-029 After reset, out_valid, sum, carry_out and overflow are 0.
REQ-030 Reset mid-operation discards all in-flight beats; beats offered during reset are not accepted.
REQ-031 The first acceptance is possible in the first cycle after rst falls.

Configuration
REQ-032 Macro PIPE_ADDER_SAT_EN selects saturating arithmetic.
REQ-033 With PIPE_ADDER_SAT_EN defined, a signed overflow clamps sum to the signed maximum (positive overflow) or the signed minimum (negative overflow); overflow and carry_out still report the unclamped result.
REQ-034 Without PIPE_ADDER_SAT_EN, sum wraps modulo 2^BIT_WIDTH; no saturation logic is present.

Structure
REQ-035 Package adder_pkg holds op_t (OP_ADD, OP_SUB), the default BIT_WIDTH/STAGES constants, and the result payload struct (sum, carry_out, overflow).
REQ-036 Sub-module pipe_adder_slot implements one valid+payload register slot with load/advance control; pipe_adder instantiates STAGES of them via generate.
REQ-037 The arithmetic and saturation logic stay in pipe_adder.

Verification (BIT_WIDTH=4, STAGES=2, out_ready high unless stated)
REQ-038 ADD a=7 b=1 cin=0 -> 2 cycles later sum=8, carry_out=0, overflow=1; with PIPE_ADDER_SAT_EN, sum=7.
REQ-039 ADD a=F b=1 cin=0 -> sum=0, carry_out=1, overflow=0; SUB a=3 b=5 cin=0 -> sum=E, carry_out=0, overflow=0.
REQ-040 Backpressure: stream 4 beats (a=1..4, b=0) with out_ready low for cycles 0-4 -> in_ready falls after 2 accepts; after out_ready rises, outputs are 1,2,3,4 in order with none lost.
REQ-041 Bubbles: in_valid pattern 1,0,1,1,0,1 -> each result appears exactly 2 cycles after its accept, with out_valid gaps mirroring the input gaps.
REQ-042 Reset mid-flight: accept 2 beats, assert rst for 1 cycle -> out_valid=0 next cycle, neither beat ever emerges, and in_ready=0 during rst.
REQ-043 Full pipe plus a simultaneous accept and drain for 5 cycles -> in_ready stays 1 and exactly one result is emitted per cycle.
